// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory answering single-cycle CPU requests.
// Optional wait states are compiled in with `define DMEM_WAIT_STATE_EN.
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 12
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic              req_err
);

`ifdef DMEM_WAIT_STATE_EN
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd2
    } state_t;
`endif

    state_t state;
    state_t state_n;

    logic [31:0]       mem [2**ADDR_W];

    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;

`ifdef DMEM_WAIT_STATE_EN
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic              cap_en;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
`endif

    // State register; reset wins over any coincident request or access.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and access strobe; live inputs are used on the capture edge,
    // the captured copy once the request has waited.
    always_comb begin
        state_n   = state;
        acc_en    = 1'b0;
        acc_we    = we;
        acc_addr  = addr;
        acc_wdata = wdata;
`ifdef DMEM_WAIT_STATE_EN
        cnt_n     = cnt;
        cap_en    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (req) begin
`ifdef DMEM_WAIT_STATE_EN
                    if (WAIT_CYCLES == 0) begin
                        acc_en  = 1'b1;
                        state_n = ACK;
                    end else begin
                        cap_en  = 1'b1;
                        cnt_n   = CNT_W'(WAIT_CYCLES);
                        state_n = WAIT;
                    end
`else
                    acc_en  = 1'b1;
                    state_n = ACK;
`endif
                end
            end
`ifdef DMEM_WAIT_STATE_EN
            WAIT: begin
                acc_we    = cap_we;
                acc_addr  = cap_addr;
                acc_wdata = cap_wdata;
                cnt_n     = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    acc_en  = 1'b1;
                    state_n = ACK;
                end
            end
`endif
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef DMEM_WAIT_STATE_EN
    // Wait-state counter.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end

    // Request capture; only loaded when an IDLE request is accepted.
    always_ff @(posedge clk_cpu) begin
        if (!reset && cap_en) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
        end
    end
`endif

    // Storage write; contents survive reset, but a reset edge aborts the write.
    always_ff @(posedge clk_cpu) begin
        if (!reset && acc_en && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    // Read data register; only reads update it, so it holds across writes.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            rdata <= '0;
        end else if (acc_en && !acc_we) begin
            rdata <= mem[acc_addr];
        end
    end

    // Sticky flag for a request that arrives while a transaction is in flight.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            req_err <= 1'b0;
        end else if (req && state != IDLE) begin
            req_err <= 1'b1;
        end
    end

    assign ack  = (state == ACK);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Covers both builds; latency follows DMEM_WAIT_STATE_EN.
module tb_dmem_responder;

    localparam int W  = 2;
    localparam int AW = 12;
`ifdef DMEM_WAIT_STATE_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
        logic [31:0] due;
    } sb_t;

    logic          clk_cpu = 1'b0;
    logic          reset   = 1'b1;
    logic          req     = 1'b0;
    logic          we      = 1'b0;
    logic [AW-1:0] addr    = '0;
    logic [31:0]   wdata   = '0;
    logic [31:0]   rdata;
    logic          ack;
    logic          busy;
    logic          req_err;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   cyc   = '0;
    sb_t           sb [$];
    logic [31:0]   model [int];

    dmem_responder #(
        .WAIT_CYCLES(W),
        .ADDR_W     (AW)
    ) dut (
        .clk_cpu(clk_cpu),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ack    (ack),
        .busy   (busy),
        .req_err(req_err)
    );

    always #5 clk_cpu = ~clk_cpu;

    always @(posedge clk_cpu) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    always @(negedge clk_cpu) begin
        if (!reset && ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("ack_cycle", cyc, e.due);
                if (e.rd) check("rdata", rdata, e.data);
            end
        end
    end

    task automatic push_req(input logic w, input logic [AW-1:0] a,
                            input logic [31:0] d);
        sb_t e;
        e.rd  = !w;
        e.due = cyc + LAT;
        e.data = '0;
        if (w) model[int'(a)] = d;
        else   e.data = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
        sb.push_back(e);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic do_req(input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d);
        push_req(w, a, d);
        tick();
        req = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            check("busy_hi", {31'd0, busy}, 32'd1);
            tick();
        end
        check("busy_lo", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, req_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        tick();

        do_req(1'b1, 12'h005, 32'hDEADBEEF);
        do_req(1'b0, 12'h005, 32'h0);

        do_req(1'b1, 12'hFFF, 32'h12345678);
        do_req(1'b0, 12'hFFF, 32'h0);
        do_req(1'b1, 12'h000, 32'h00000000);
        check("rdata_hold", rdata, 32'h12345678);

        for (int i = 0; i < 6; i++) begin
            do_req(1'b1, AW'(12'h100 + i * 37), $urandom);
        end
        for (int i = 5; i >= 0; i--) begin
            do_req(1'b0, AW'(12'h100 + i * 37), 32'h0);
        end
        check("b2b_no_err", {31'd0, req_err}, 32'd0);

        do_req(1'b1, 12'h010, 32'h11111111);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 12'h010;
        wdata = 32'hAAAAAAAA;
        for (int k = 0; k < LAT; k++) begin
            if (k == LAT - 1) reset = 1'b1;
            tick();
            req = 1'b0;
        end
        reset = 1'b0;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {31'd0, req_err}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        tick();
        do_req(1'b0, 12'h010, 32'h0);

        push_req(1'b1, 12'h020, 32'hCAFEF00D);
        tick();
        req   = 1'b1;
        we    = 1'b1;
        addr  = 12'h020;
        wdata = 32'h0BADBAD0;
        tick();
        req = 1'b0;
        check("stray_err", {31'd0, req_err}, 32'd1);
        for (int i = 0; i < LAT - 1; i++) tick();
        tick();
        check("err_sticky", {31'd0, req_err}, 32'd1);
        do_req(1'b0, 12'h020, 32'h0);
        check("err_sticky2", {31'd0, req_err}, 32'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", {31'd0, req_err}, 32'd0);
        do_req(1'b0, 12'hFFF, 32'h0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, wait states inserted before each access completes (used only when DMEM_WAIT_STATE_EN is defined).
REQ-002 Parameter ADDR_W, default 12, word-address width; storage depth is 2^ADDR_W words of 32 bits.
REQ-003 clk_cpu  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  single-cycle request pulse from the CPU-side initiator.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  ADDR_W  word address; sampled with req.
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 rdata  output  32  registered read data; valid while ack=1 and held until the next read completes.
REQ-010 ack  output  1  completion strobe, high for exactly one cycle per accepted request.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 req_err  output  1  sticky flag: request arrived while not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and ACK, and SHALL leave reset in IDLE.
REQ-014 In IDLE with req=1, the block SHALL capture we, addr and wdata on that edge; in every other state, req SHALL be ignored for capture.
REQ-015 The access edge SHALL write wdata to mem[addr] for writes, or load rdata from mem[addr] for reads; rdata SHALL be unchanged by writes.
REQ-016 Without wait states, the capture edge SHALL also be the access edge, and the FSM SHALL go IDLE->ACK, giving ack one cycle after the req cycle.
REQ-017 With wait states and WAIT_CYCLES=W>0, the capture edge SHALL load the counter with W and go to WAIT; each WAIT edge decrements; the edge at count=1 is the access edge and goes to ACK; ack appears W+1 cycles after the req cycle.
REQ-018 With WAIT_CYCLES=0, behaviour SHALL be identical to REQ-016.
REQ-019 ACK SHALL last exactly one cycle and then return to IDLE unconditionally, so the minimum request spacing is 2 cycles without wait states and W+2 cycles with them.
REQ-020 Any req=1 sampled in WAIT or ACK SHALL set req_err to 1, and req_err SHALL stay 1 until reset; the stray request SHALL neither be queued nor corrupt the in-flight transaction.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W, with no out-of-range condition.
REQ-022 busy SHALL be 0 in IDLE and 1 in WAIT and ACK.

Reset
REQ-023 While reset=1 at an edge: state SHALL become IDLE, and ack, busy, req_err, the counter and rdata SHALL all become 0.
REQ-024 Reset SHALL take priority over a coincident access edge, so a pending write is aborted and memory is not modified.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 A req coincident with reset SHALL be discarded.

Configuration
REQ-027 When the macro DMEM_WAIT_STATE_EN is defined, the WAIT state and the counter SHALL be compiled in and behave per REQ-017.
REQ-028 When DMEM_WAIT_STATE_EN is undefined, the WAIT state and the counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and timing SHALL follow REQ-016.

Verification
REQ-029 Macro undefined: write addr=0x005, wdata=0xDEADBEEF, then a read of 0x005 -> each ack arrives one cycle after its req, and rdata=0xDEADBEEF during the read ack.
REQ-030 Macro defined, W=2: read request -> busy=1 for 3 cycles, and ack arrives exactly 3 cycles after req.
REQ-031 Macro defined, W=2: req pulse in the cycle after a write is accepted -> req_err=1 and stays 1, only one ack occurs, and the original write data is stored.
REQ-032 Macro defined, W=3: write to 0x010 (old contents 0x11111111), with reset asserted on the access edge -> after reset, all outputs are 0, and a read of 0x010 returns 0x11111111.
REQ-033 Write 0x12345678 to addr 0xFFF, then read 0xFFF, then write 0x0 to 0x000 -> the read returns 0x12345678, and rdata stays 0x12345678 through the later write.
REQ-034 Back-to-back reads spaced at the minimum interval (REQ-019) -> every request acked, with no req_err.
